wishbone_bus_if: RTL and testbench

WISHBONE_BUS_IF -- requirements
Module: wishbone_bus_if

---
 rtl/wishbone_bus_if_pkg.sv | 24 ++
 rtl/wishbone_bus_if.sv | 143 ++++++++++++++
 tb/tb_wishbone_bus_if.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/wishbone_bus_if_pkg.sv
// Shared bus definitions for the CPU-to-Wishbone master bridge:
// widths, FSM state encodings and the registered request payload.
package wishbone_bus_if_pkg;

  localparam int unsigned WB_AW    = 32;
  localparam int unsigned WB_DW    = 32;
  localparam int unsigned WB_SW    = WB_DW / 8;
  localparam int unsigned STALL_W  = 6;
  localparam int unsigned TO_CNT_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE           = 2'd0,
    ST_BUSY           = 2'd1,
    ST_WAIT_FOR_STALL = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
    logic             we;
    logic [WB_SW-1:0] sel;
  } wb_req_t;

endpackage

// File: rtl/wishbone_bus_if.sv
// CPU-to-Wishbone master bridge: one single-beat access at a time, pipeline
// stall handshake, flush abort and a bounded wait for ack (timeout).
module wishbone_bus_if
  import wishbone_bus_if_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall_i,
  input  logic               flush_i,
  input  logic               cpu_ce_i,
  input  logic               cpu_we_i,
  input  logic [WB_AW-1:0]   cpu_addr_i,
  input  logic [WB_DW-1:0]   cpu_data_i,
  input  logic [WB_SW-1:0]   cpu_sel_i,
  output logic [WB_DW-1:0]   cpu_data_o,
  input  logic [WB_DW-1:0]   wb_data_i,
  input  logic               wb_ack_i,
  output logic [WB_AW-1:0]   wb_addr_o,
  output logic [WB_DW-1:0]   wb_data_o,
  output logic               wb_we_o,
  output logic [WB_SW-1:0]   wb_sel_o,
  output logic               wb_stb_o,
  output logic               wb_cyc_o,
  output logic               stallreq_o,
  output logic               bus_err_o
);

  wb_state_e             state_q, state_d;
  wb_req_t               req_q, req_d;
  logic                  stb_q, stb_d;
  logic [TO_CNT_W-1:0]   cnt_q, cnt_d;
  logic [WB_DW-1:0]      rd_buf_q, rd_buf_d;
  logic                  bus_err_q, bus_err_d;
  logic                  timeout_hit_c;

  // cnt_q counts ack-less BUSY cycles already elapsed; this is the last allowed one
  assign timeout_hit_c = (cnt_q == TO_CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    stb_d     = stb_q;
    cnt_d     = cnt_q;
    rd_buf_d  = rd_buf_q;
    bus_err_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cpu_ce_i && !flush_i) begin
          req_d.addr = cpu_addr_i;
          req_d.data = cpu_data_i;
          req_d.we   = cpu_we_i;
          req_d.sel  = cpu_sel_i;
          stb_d      = 1'b1;
          cnt_d      = '0;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (flush_i) begin
          req_d   = '0;
          stb_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (wb_ack_i || timeout_hit_c) begin
          req_d = '0;
          stb_d = 1'b0;
          cnt_d = '0;
          if (wb_ack_i) begin
            if (!req_q.we) begin
              rd_buf_d = wb_data_i;
            end
          end else begin
            rd_buf_d  = '0;
            bus_err_d = 1'b1;
          end
          state_d = (stall_i != '0) ? ST_WAIT_FOR_STALL : ST_IDLE;
        end else begin
          cnt_d = cnt_q + TO_CNT_W'(1);
        end
      end
      ST_WAIT_FOR_STALL: begin
        if (stall_i == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      stb_q     <= 1'b0;
      cnt_q     <= '0;
      rd_buf_q  <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      stb_q     <= stb_d;
      cnt_q     <= cnt_d;
      rd_buf_q  <= rd_buf_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Stall request and read return follow the current state combinationally
  always_comb begin
    stallreq_o = 1'b0;
    cpu_data_o = '0;
    unique case (state_q)
      ST_IDLE: begin
        stallreq_o = cpu_ce_i && !flush_i;
      end
      ST_BUSY: begin
        stallreq_o = !wb_ack_i && !timeout_hit_c;
        if (wb_ack_i && !req_q.we) begin
          cpu_data_o = wb_data_i;
        end
      end
      ST_WAIT_FOR_STALL: begin
        cpu_data_o = rd_buf_q;
      end
      default: begin
        stallreq_o = 1'b0;
      end
    endcase
  end

  assign wb_addr_o = req_q.addr;
  assign wb_data_o = req_q.data;
  assign wb_we_o   = req_q.we;
  assign wb_sel_o  = req_q.sel;
  assign wb_stb_o  = stb_q;
  assign wb_cyc_o  = stb_q;
  assign bus_err_o = bus_err_q;

endmodule

// File: tb/tb_wishbone_bus_if.sv
// Cycle-by-cycle vector bench for wishbone_bus_if (TIMEOUT_CYC=4) with
// scoreboarded expectations and hand-written reset sequences.
module tb_wishbone_bus_if;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic        cpu_ce_i, cpu_we_i;
  logic [31:0] cpu_addr_i, cpu_data_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_data_o;
  logic [31:0] wb_data_i;
  logic        wb_ack_i;
  logic [31:0] wb_addr_o, wb_data_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o, wb_cyc_o;
  logic        stallreq_o, bus_err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wishbone_bus_if #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_data_i(cpu_data_i), .cpu_sel_i(cpu_sel_i), .cpu_data_o(cpu_data_o),
    .wb_data_i(wb_data_i), .wb_ack_i(wb_ack_i), .wb_addr_o(wb_addr_o),
    .wb_data_o(wb_data_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .stallreq_o(stallreq_o),
    .bus_err_o(bus_err_o)
  );

  typedef struct {
    logic        ce, we, fl, ack;
    logic [5:0]  stall;
    logic [31:0] addr, wdat;
    logic [3:0]  sel;
    logic [31:0] rdat;
    logic        sr;
    logic [31:0] cdo;
    logic        cyc, weo;
    logic [31:0] ao, dout;
    logic [3:0]  so;
    logic        err;
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];

  function automatic vec_t mk(
    input logic ce, we, fl, ack, input logic [5:0] st,
    input logic [31:0] a, wd, input logic [3:0] s, input logic [31:0] rd,
    input logic sr, input logic [31:0] cdo, input logic cyc, weo,
    input logic [31:0] ao, dout, input logic [3:0] so, input logic err);
    vec_t v;
    v.ce = ce; v.we = we; v.fl = fl; v.ack = ack; v.stall = st;
    v.addr = a; v.wdat = wd; v.sel = s; v.rdat = rd;
    v.sr = sr; v.cdo = cdo; v.cyc = cyc; v.weo = weo;
    v.ao = ao; v.dout = dout; v.so = so; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    cpu_ce_i = v.ce; cpu_we_i = v.we; flush_i = v.fl; wb_ack_i = v.ack;
    stall_i = v.stall; cpu_addr_i = v.addr; cpu_data_i = v.wdat;
    cpu_sel_i = v.sel; wb_data_i = v.rdat;
  endtask

  task automatic idle_inputs();
    drive(mk(0,0,0,0,6'h0, 0,0,4'h0,0, 0,0,0,0,0,0,4'h0,0));
  endtask

  task automatic compare_row(input int i, input vec_t e);
    chk($sformatf("row%0d stallreq", i), 32'(stallreq_o), 32'(e.sr));
    chk($sformatf("row%0d cpu_data", i), cpu_data_o, e.cdo);
    chk($sformatf("row%0d cyc", i), 32'(wb_cyc_o), 32'(e.cyc));
    chk($sformatf("row%0d stb", i), 32'(wb_stb_o), 32'(e.cyc));
    chk($sformatf("row%0d we", i), 32'(wb_we_o), 32'(e.weo));
    chk($sformatf("row%0d addr", i), wb_addr_o, e.ao);
    chk($sformatf("row%0d wdata", i), wb_data_o, e.dout);
    chk($sformatf("row%0d sel", i), 32'(wb_sel_o), 32'(e.so));
    chk($sformatf("row%0d bus_err", i), 32'(bus_err_o), 32'(e.err));
  endtask

  initial begin
    // Write with stall at ack: rd_buf must still read back 0
    vecs.push_back(mk(1,1,0,0,6'h00, 32'h200,32'h12345678,4'hF,0, 1,0,0,0,0,0,4'h0,0));
    vecs.push_back(mk(0,0,0,0,6'h00, 0,0,4'h0,0, 1,0,1,1,32'h200,32'h12345678,4'hF,0));
    vecs.push_back(mk(0,0,0,1,6'h01, 0,0,4'h0,32'hFFFFFFFF, 0,0,1,1,32'h200,32'h12345678,4'hF,0));
    vecs.push_back(mk(0,0,0,0,6'h01, 0,0,4'h0,0, 0,0,0,0,0,0,4'h0,0));
    vecs.push_back(mk(0,0,0,0,6'h00, 0,0,4'h0,0, 0,0,0,0,0,0,4'h0,0));
    // Read, ack on 3rd BUSY cycle, then back-to-back request
    vecs.push_back(mk(1,0,0,0,6'h00, 32'h100,0,4'hF,0, 1,0,0,0,0,0,4'h0,0));
    vecs.push_back(mk(1,0,0,0,6'h00, 32'h100,0,4'hF,0, 1,0,1,0,32'h100,0,4'hF,0));
    vecs.push_back(mk(1,0,0,0,6'h00, 32'h100,0,4'hF,0, 1,0,1,0,32'h100,0,4'hF,0));
    vecs.push_back(mk(1,0,0,1,6'h00, 32'h100,0,4'hF,32'hDEADBEEF, 0,32'hDEADBEEF,1,0,32'h100,0,4'hF,0));
    vecs.push_back(mk(1,0,0,0,6'h00, 32'h104,0,4'hF,0, 1,0,0,0,0,0,4'h0,0));
    vecs.push_back(mk(0,0,0,1,6'h00, 0,0,4'h0,32'h0BADF00D, 0,32'h0BADF00D,1,0,32'h104,0,4'hF,0));
    vecs.push_back(mk(0,0,0,0,6'h00, 0,0,4'h0,0, 0,0,0,0,0,0,4'h0,0));
    // Read with stall at ack; ce/ack ignored while waiting and in IDLE
    vecs.push_back(mk(1,0,0,0,6'h00, 32'h300,0,4'h3,0, 1,0,0,0,0,0,4'h0,0));
    vecs.push_back(mk(0,0,0,1,6'h03, 0,0,4'h0,32'hA5A5A5A5, 0,32'hA5A5A5A5,1,0,32'h300,0,4'h3,0));
    vecs.push_back(mk(1,0,0,1,6'h03, 32'h900,0,4'hF,32'h11111111, 0,32'hA5A5A5A5,0,0,0,0,4'h0,0));
    vecs.push_back(mk(0,0,0,0,6'h03, 0,0,4'h0,0, 0,32'hA5A5A5A5,0,0,0,0,4'h0,0));
    vecs.push_back(mk(0,0,0,0,6'h00, 0,0,4'h0,0, 0,32'hA5A5A5A5,0,0,0,0,4'h0,0));
    vecs.push_back(mk(0,0,0,1,6'h00, 0,0,4'h0,32'h22222222, 0,0,0,0,0,0,4'h0,0));
    // Flush with ack in 2nd BUSY cycle; write then exposes unchanged rd_buf
    vecs.push_back(mk(1,0,0,0,6'h00, 32'h400,0,4'hF,0, 1,0,0,0,0,0,4'h0,0));
    vecs.push_back(mk(0,0,0,0,6'h00, 0,0,4'h0,0, 1,0,1,0,32'h400,0,4'hF,0));
    vecs.push_back(mk(0,0,1,1,6'h00, 0,0,4'h0,32'h55555555, 0,32'h55555555,1,0,32'h400,0,4'hF,0));
    vecs.push_back(mk(0,0,0,0,6'h03, 0,0,4'h0,0, 0,0,0,0,0,0,4'h0,0));
    vecs.push_back(mk(1,1,0,0,6'h00, 32'h500,32'hCAFEF00D,4'hC,0, 1,0,0,0,0,0,4'h0,0));
    vecs.push_back(mk(0,0,0,1,6'h01, 0,0,4'h0,32'h33333333, 0,0,1,1,32'h500,32'hCAFEF00D,4'hC,0));
    vecs.push_back(mk(0,0,0,0,6'h01, 0,0,4'h0,0, 0,32'hA5A5A5A5,0,0,0,0,4'h0,0));
    vecs.push_back(mk(0,0,0,0,6'h00, 0,0,4'h0,0, 0,32'hA5A5A5A5,0,0,0,0,4'h0,0));
    vecs.push_back(mk(1,0,1,0,6'h00, 32'h800,0,4'hF,0, 0,0,0,0,0,0,4'h0,0));
    vecs.push_back(mk(0,0,0,0,6'h00, 0,0,4'h0,0, 0,0,0,0,0,0,4'h0,0));
    // Timeout after 4 ack-less BUSY cycles, then rd_buf reads back cleared
    vecs.push_back(mk(1,0,0,0,6'h00, 32'h600,0,4'hF,0, 1,0,0,0,0,0,4'h0,0));
    vecs.push_back(mk(1,0,0,0,6'h00, 32'h600,0,4'hF,0, 1,0,1,0,32'h600,0,4'hF,0));
    vecs.push_back(mk(1,0,0,0,6'h00, 32'h600,0,4'hF,0, 1,0,1,0,32'h600,0,4'hF,0));
    vecs.push_back(mk(1,0,0,0,6'h00, 32'h600,0,4'hF,0, 1,0,1,0,32'h600,0,4'hF,0));
    vecs.push_back(mk(1,0,0,0,6'h00, 32'h600,0,4'hF,0, 0,0,1,0,32'h600,0,4'hF,0));
    vecs.push_back(mk(0,0,0,0,6'h00, 0,0,4'h0,0, 0,0,0,0,0,0,4'h0,1));
    vecs.push_back(mk(0,0,0,0,6'h00, 0,0,4'h0,0, 0,0,0,0,0,0,4'h0,0));
    vecs.push_back(mk(1,1,0,0,6'h00, 32'h700,32'h1,4'h1,0, 1,0,0,0,0,0,4'h0,0));
    vecs.push_back(mk(0,0,0,1,6'h02, 0,0,4'h0,32'h44444444, 0,0,1,1,32'h700,32'h1,4'h1,0));
    vecs.push_back(mk(0,0,0,0,6'h00, 0,0,4'h0,0, 0,0,0,0,0,0,4'h0,0));
    vecs.push_back(mk(0,0,0,0,6'h00, 0,0,4'h0,0, 0,0,0,0,0,0,4'h0,0));

    rst = 1'b0;
    idle_inputs();
    #2;
    compare_row(-1, mk(0,0,0,0,6'h0, 0,0,4'h0,0, 0,0,0,0,0,0,4'h0,0));
    #15 rst = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      drive(vecs[i]);
      sb_q.push_back(vecs[i]);
      @(negedge clk);
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard row%0d: got empty queue expected entry", i);
      end else begin
        compare_row(i, sb_q.pop_front());
      end
    end

    // Reset asserted between edges while BUSY drops the bus immediately
    @(posedge clk); #1;
    drive(mk(1,0,0,0,6'h0, 32'hA00,0,4'hF,0, 0,0,0,0,0,0,4'h0,0));
    @(posedge clk); #1;
    idle_inputs();
    #1 chk("pre_reset cyc", 32'(wb_cyc_o), 32'h1);
    rst = 1'b0;
    #1;
    chk("mid_reset cyc", 32'(wb_cyc_o), 32'h0);
    chk("mid_reset stb", 32'(wb_stb_o), 32'h0);
    chk("mid_reset addr", wb_addr_o, 32'h0);
    chk("mid_reset sel", 32'(wb_sel_o), 32'h0);
    chk("mid_reset stallreq", 32'(stallreq_o), 32'h0);
    chk("mid_reset cpu_data", cpu_data_o, 32'h0);

    // Release between edges with a request pending: access starts at next edge
    @(posedge clk); #1;
    chk("in_reset cyc", 32'(wb_cyc_o), 32'h0);
    rst = 1'b1;
    drive(mk(1,0,0,0,6'h0, 32'hB00,0,4'hF,0, 0,0,0,0,0,0,4'h0,0));
    #1;
    chk("post_release cyc", 32'(wb_cyc_o), 32'h0);
    chk("post_release stallreq", 32'(stallreq_o), 32'h1);
    @(posedge clk); #1;
    chk("first_access cyc", 32'(wb_cyc_o), 32'h1);
    chk("first_access addr", wb_addr_o, 32'hB00);
    drive(mk(0,0,0,1,6'h0, 0,0,4'h0,32'h77777777, 0,0,0,0,0,0,4'h0,0));
    #1;
    chk("first_access rdata", cpu_data_o, 32'h77777777);
    chk("first_access stallreq", 32'(stallreq_o), 32'h0);
    @(posedge clk); #1;
    idle_inputs();
    #1 chk("first_access done cyc", 32'(wb_cyc_o), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
